// File: rtl/pair_tx_pkg.sv
// pair_tx shared types and constants.
// Operand pair layout, FSM encoding, expected-length helper.
package pair_tx_pkg;

  localparam int OP_W        = 8;
  localparam int CNT_W       = 9;
  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RFD,
    S_OFFER,
    S_WAIT_HI,
    S_COUNT
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0] x;
    logic [OP_W-1:0] y;
  } pair_t;

  // A zero max makes the consumer counter wrap, giving 256 cycles.
  function automatic logic [CNT_W-1:0] exp_of(input pair_t p);
    logic [OP_W-1:0]  m;
    logic [CNT_W-1:0] e;
    if ($signed(p.x) > $signed(p.y)) m = p.x;
    else                             m = p.y;
    e = {1'b0, m};
    if (e == '0) e = CNT_W'(256);
    return e;
  endfunction

endpackage

// File: rtl/pair_fifo.sv
// Synchronous FIFO of operand pairs.
// Head read is valid whenever not empty.
module pair_fifo
  import pair_tx_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  push_i,
  input  logic  pop_i,
  input  pair_t din_i,
  output pair_t head_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int AW = $clog2(DEPTH);

  pair_t         mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/pair_tx.sv
// Operand-pair transmitter over the rfd/dav handshake.
// Measures the consumer pulse and flags mismatch or timeout.
module pair_tx
  import pair_tx_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [OP_W-1:0]  load_x,
  input  logic [OP_W-1:0]  load_y,
  output logic             full,
  output logic             ovf,
  input  logic             rfd_x,
  input  logic             rfd_y,
  output logic             dav_x,
  output logic             dav_y,
  output logic [OP_W-1:0]  x,
  output logic [OP_W-1:0]  y,
  input  logic             out,
  output logic [CNT_W-1:0] meas,
  output logic             meas_valid,
  output logic             err,
  output logic             busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e state_q, state_d;

  pair_t head;
  logic  f_full, f_empty;
  logic  push, pop;
  logic  rfd_all, rfd_none;

  logic [OP_W-1:0]  x_q, x_d;
  logic [OP_W-1:0]  y_q, y_d;
  logic             dav_q, dav_d;
  logic [CNT_W-1:0] exp_q, exp_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] meas_q, meas_d;
  logic             mv_q, mv_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             tmo;

  assign rfd_all  = rfd_x & rfd_y;
  assign rfd_none = ~rfd_x & ~rfd_y;
  assign pop      = (state_q == S_OFFER) & rfd_none;
  // A full FIFO still accepts when the head leaves this cycle.
  assign push     = load & (~f_full | pop);
  assign ovf_d    = load & f_full & ~pop;
  assign tmo      = (tmr_q == TW'(TIMEOUT - 1));

  pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({load_x, load_y}),
    .head_o  (head),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      dav_q   <= 1'b1;
      exp_q   <= '0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      meas_q  <= '0;
      mv_q    <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dav_q   <= dav_d;
      exp_q   <= exp_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      meas_q  <= meas_d;
      mv_q    <= mv_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (!f_empty) state_d = S_WAIT_RFD;
      S_WAIT_RFD: if (rfd_all)  state_d = S_OFFER;
      S_OFFER:    if (rfd_none) state_d = S_WAIT_HI;
      S_WAIT_HI: begin
        if (out)      state_d = S_COUNT;
        else if (tmo) state_d = S_IDLE;
      end
      S_COUNT:    if (!out)     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    dav_d  = dav_q;
    exp_d  = exp_q;
    tmr_d  = tmr_q;
    cnt_d  = cnt_q;
    meas_d = meas_q;
    mv_d   = 1'b0;
    err_d  = err_q;
    unique case (state_q)
      S_IDLE: dav_d = 1'b1;
      S_WAIT_RFD: begin
        if (rfd_all) begin
          x_d   = head.x;
          y_d   = head.y;
          dav_d = 1'b0;
          exp_d = exp_of(head);
        end
      end
      S_OFFER: begin
        if (rfd_none) begin
          dav_d = 1'b1;
          tmr_d = '0;
        end
      end
      S_WAIT_HI: begin
        if (out) begin
          cnt_d = CNT_W'(1);
        end else if (tmo) begin
          meas_d = '0;
          err_d  = 1'b1;
          mv_d   = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_COUNT: begin
        if (out) begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else begin
          meas_d = cnt_q;
          err_d  = (cnt_q != exp_q);
          mv_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign full       = f_full;
  assign ovf        = ovf_q;
  assign dav_x      = dav_q;
  assign dav_y      = dav_q;
  assign x          = x_q;
  assign y          = y_q;
  assign meas       = meas_q;
  assign meas_valid = mv_q;
  assign err        = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_pair_tx.sv
// Directed self-checking bench for pair_tx.
// Inputs driven and outputs sampled on the falling edge.
module tb_pair_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_x = '0;
  logic [7:0] load_y = '0;
  logic       full, ovf;
  logic       rfd_x = 1'b0;
  logic       rfd_y = 1'b0;
  logic       dav_x, dav_y;
  logic [7:0] x, y;
  logic       out = 1'b0;
  logic [8:0] meas;
  logic       meas_valid, err, busy;

  int errs = 0;
  int checks = 0;

  always #5 clock = ~clock;

  pair_tx #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_x     (load_x),
    .load_y     (load_y),
    .full       (full),
    .ovf        (ovf),
    .rfd_x      (rfd_x),
    .rfd_y      (rfd_y),
    .dav_x      (dav_x),
    .dav_y      (dav_y),
    .x          (x),
    .y          (y),
    .out        (out),
    .meas       (meas),
    .meas_valid (meas_valid),
    .err        (err),
    .busy       (busy)
  );

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    @(negedge clock);
    load = 1'b1; load_x = a; load_y = b;
    @(negedge clock);
    load = 1'b0;
  endtask

  // Consumer model: handshake, then an out pulse of plen cycles.
  task automatic consume(input int plen,
                         output logic [7:0] ox, output logic [7:0] oy,
                         output logic [8:0] m, output logic e,
                         output bit ok);
    int n;
    ok = 1'b1; ox = '0; oy = '0; m = '0; e = 1'b0;
    @(negedge clock);
    rfd_x = 1'b1; rfd_y = 1'b1;
    n = 0;
    @(negedge clock);
    while (dav_x !== 1'b0 && n < 20) begin
      @(negedge clock); n++;
    end
    if (dav_x !== 1'b0) ok = 1'b0;
    ox = x; oy = y;
    rfd_x = 1'b0; rfd_y = 1'b0;
    @(negedge clock);
    if (plen > 0) begin
      out = 1'b1;
      repeat (plen) @(negedge clock);
      out = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clock); n++;
    end while (meas_valid !== 1'b1 && n < 40);
    if (meas_valid !== 1'b1) ok = 1'b0;
    m = meas; e = err;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({dav_x, dav_y, full, ovf, meas_valid, err, busy, x, y, meas}
        !== {1'b1, 1'b1, 5'b0, 8'd0, 8'd0, 9'd0}) begin
      errs++;
      $display("FAIL reset_state: dav=%b%b full=%b ovf=%b mv=%b err=%b busy=%b x=%0d y=%0d meas=%0d, want dav=11 rest 0",
               dav_x, dav_y, full, ovf, meas_valid, err, busy, x, y, meas);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic();
    logic [7:0] ox, oy; logic [8:0] m; logic e; bit ok;
    push_pair(8'd5, 8'd3);
    consume(5, ox, oy, m, e, ok);
    checks++;
    if (!ok) begin errs++; $display("FAIL basic_hs: timed out"); end
    checks++;
    if ({ox, oy} !== {8'd5, 8'd3}) begin
      errs++; $display("FAIL basic_xy: got %0d,%0d want 5,3", ox, oy);
    end
    checks++;
    if ({m, e} !== {9'd5, 1'b0}) begin
      errs++; $display("FAIL basic_meas: got meas=%0d err=%b want 5/0", m, e);
    end
    checks++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL basic_busy_at_mv: got %b want 0", busy);
    end
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, full, meas_valid} !== 3'b000) begin
      errs++; $display("FAIL basic_empty: busy=%b full=%b mv=%b want 000", busy, full, meas_valid);
    end
  endtask

  task automatic test_stretch();
    logic [7:0] ox, oy; logic [8:0] m; logic e; bit ok;
    push_pair(8'hFC, 8'd2);
    consume(3, ox, oy, m, e, ok);
    checks++;
    if (!ok || {ox, oy} !== {8'hFC, 8'd2}) begin
      errs++; $display("FAIL stretch_xy: ok=%b got %h,%h want fc,02", ok, ox, oy);
    end
    checks++;
    if ({m, e} !== {9'd3, 1'b1}) begin
      errs++; $display("FAIL stretch_meas: got meas=%0d err=%b want 3/1", m, e);
    end
  endtask

  task automatic test_zero_wrap();
    logic [7:0] ox, oy; logic [8:0] m; logic e; bit ok;
    push_pair(8'd0, 8'hFF);
    consume(256, ox, oy, m, e, ok);
    checks++;
    if (!ok || {ox, oy} !== {8'd0, 8'hFF}) begin
      errs++; $display("FAIL zero_xy: ok=%b got %h,%h want 00,ff", ok, ox, oy);
    end
    checks++;
    if ({m, e} !== {9'd256, 1'b0}) begin
      errs++; $display("FAIL zero_meas: got meas=%0d err=%b want 256/0", m, e);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] ox, oy; logic [8:0] m; logic e; bit ok;
    logic [7:0] px [5] = '{8'd1, 8'd7, 8'hFB, 8'd10, 8'd99};
    logic [7:0] py [5] = '{8'd2, 8'hFD, 8'hFA, 8'd10, 8'd99};
    int         pl [4] = '{2, 7, 3, 4};
    logic [8:0] wm [4] = '{9'd2, 9'd7, 9'd3, 9'd4};
    logic       we [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      load = 1'b1; load_x = px[i]; load_y = py[i];
      if (i == 3) begin
        checks++;
        if (full !== 1'b0) begin
          errs++; $display("FAIL fifo_not_full_at3: got %b want 0", full);
        end
      end
      if (i == 4) begin
        checks++;
        if (full !== 1'b1) begin
          errs++; $display("FAIL fifo_full_at4: got %b want 1", full);
        end
      end
      @(negedge clock);
    end
    load = 1'b0;
    checks++;
    if ({ovf, full} !== 2'b11) begin
      errs++; $display("FAIL fifo_ovf: ovf=%b full=%b want 11", ovf, full);
    end
    @(negedge clock);
    checks++;
    if (ovf !== 1'b0) begin
      errs++; $display("FAIL fifo_ovf_pulse: got %b want 0", ovf);
    end
    for (int i = 0; i < 4; i++) begin
      consume(pl[i], ox, oy, m, e, ok);
      checks++;
      if (!ok || {ox, oy} !== {px[i], py[i]}) begin
        errs++;
        $display("FAIL fifo_order%0d: ok=%b got %h,%h want %h,%h", i, ok, ox, oy, px[i], py[i]);
      end
      checks++;
      if ({m, e} !== {wm[i], we[i]}) begin
        errs++;
        $display("FAIL fifo_meas%0d: got %0d/%b want %0d/%b", i, m, e, wm[i], we[i]);
      end
    end
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, full} !== 2'b00) begin
      errs++; $display("FAIL fifo_drained: busy=%b full=%b want 00", busy, full);
    end
  endtask

  task automatic test_timeout();
    int n;
    push_pair(8'd9, 8'd4);
    @(negedge clock);
    rfd_x = 1'b1; rfd_y = 1'b1;
    n = 0;
    @(negedge clock);
    while (dav_x !== 1'b0 && n < 20) begin
      @(negedge clock); n++;
    end
    rfd_x = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({dav_x, dav_y, x, y} !== {2'b00, 8'd9, 8'd4}) begin
      errs++;
      $display("FAIL offer_hold: dav=%b%b x=%0d y=%0d want 00,9,4", dav_x, dav_y, x, y);
    end
    rfd_y = 1'b0;
    @(negedge clock);
    checks++;
    if ({dav_x, dav_y, x, y} !== {2'b11, 8'd9, 8'd4}) begin
      errs++;
      $display("FAIL offer_close: dav=%b%b x=%0d y=%0d want 11,9,4", dav_x, dav_y, x, y);
    end
    n = 0;
    do begin
      @(negedge clock); n++;
    end while (meas_valid !== 1'b1 && n < 40);
    checks++;
    if (n !== 16) begin
      errs++; $display("FAIL timeout_len: got %0d cycles want 16", n);
    end
    checks++;
    if ({meas_valid, meas, err} !== {1'b1, 9'd0, 1'b1}) begin
      errs++;
      $display("FAIL timeout_meas: mv=%b meas=%0d err=%b want 1/0/1", meas_valid, meas, err);
    end
    @(negedge clock);
    checks++;
    if (meas_valid !== 1'b0) begin
      errs++; $display("FAIL timeout_mv_pulse: got %b want 0", meas_valid);
    end
  endtask

  task automatic test_reset_mid();
    int  n;
    logic bad;
    push_pair(8'd1, 8'd1);
    push_pair(8'd2, 8'd2);
    push_pair(8'd3, 8'd3);
    @(negedge clock);
    rfd_x = 1'b1; rfd_y = 1'b1;
    n = 0;
    @(negedge clock);
    while (dav_x !== 1'b0 && n < 20) begin
      @(negedge clock); n++;
    end
    rfd_x = 1'b0; rfd_y = 1'b0;
    @(negedge clock);
    out = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, dav_x} !== 2'b11) begin
      errs++; $display("FAIL midrst_pre: busy=%b dav=%b want 11", busy, dav_x);
    end
    reset = 1'b1; out = 1'b0;
    @(negedge clock);
    checks++;
    if ({busy, dav_x, dav_y, full, meas_valid, x}
        !== {1'b0, 2'b11, 1'b0, 1'b0, 8'd0}) begin
      errs++;
      $display("FAIL midrst_state: busy=%b dav=%b%b full=%b mv=%b x=%0d want 0,11,0,0,0",
               busy, dav_x, dav_y, full, meas_valid, x);
    end
    reset = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (busy !== 1'b0 || meas_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errs++; $display("FAIL midrst_empty: busy or mv rose after reset, got %b want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stretch();
    test_zero_wrap();
    test_fifo_full();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
